// File: rtl/ifetch_ctrl_pkg.sv
// rtl/ifetch_ctrl_pkg.sv - shared types and constants for the instruction-fetch controller
package ifetch_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_WAIT = 2'd2,
    ST_HOLD = 2'd3
  } ifetch_state_e;

  localparam logic [31:0] IMEM_ALIGN_MASK  = 32'hFFFF_FFFC;
  localparam logic [31:0] INSTR_FAULT_WORD = 32'h0;

  // A PC with either low bit set cannot address a 32-bit instruction word.
  function automatic logic is_misaligned(input logic [31:0] pc);
    return (pc & ~IMEM_ALIGN_MASK) != 32'h0;
  endfunction

endpackage

// File: rtl/ifetch_ctrl_if.sv
// rtl/ifetch_ctrl_if.sv - instruction memory bus and decode handshake bundle
interface ifetch_ctrl_if;

  logic        o_imem_req;
  logic [31:0] o_imem_addr;
  logic        i_imem_gnt;
  logic        i_imem_rvalid;
  logic [31:0] i_imem_rdata;
  logic        i_imem_err;

  logic        o_instr_valid;
  logic [31:0] o_instr;
  logic [31:0] o_instr_pc;
  logic        o_fetch_err;
  logic        i_instr_ready;

  // Fetch controller side: drives the memory request and the decode-facing outputs.
  modport master (
    output o_imem_req, o_imem_addr,
    input  i_imem_gnt, i_imem_rvalid, i_imem_rdata, i_imem_err,
    output o_instr_valid, o_instr, o_instr_pc, o_fetch_err,
    input  i_instr_ready
  );

  // Environment side: instruction memory plus decode stage.
  modport slave (
    input  o_imem_req, o_imem_addr,
    output i_imem_gnt, i_imem_rvalid, i_imem_rdata, i_imem_err,
    input  o_instr_valid, o_instr, o_instr_pc, o_fetch_err,
    output i_instr_ready
  );

endinterface

// File: rtl/ifetch_ctrl.sv
// rtl/ifetch_ctrl.sv - single-outstanding instruction fetch FSM with held output and PC enable
module ifetch_ctrl
  import ifetch_pkg::*;
(
  input  logic          i_clk,
  input  logic          i_rst_n,
  input  logic [31:0]   i_pc,
  output logic          o_pc_en,
  input  logic          i_flush,
  ifetch_ctrl_if.master bus
);

  ifetch_state_e r_state;
  ifetch_state_e w_state_nxt;
  logic          r_drop;
  logic          w_drop_nxt;
  logic [31:0]   r_instr;
  logic [31:0]   w_instr_nxt;
  logic [31:0]   r_instr_pc;
  logic [31:0]   w_instr_pc_nxt;
  logic          r_fetch_err;
  logic          w_fetch_err_nxt;
  logic          w_pc_en;
  logic          w_req;
  logic          w_misaligned;

  assign w_misaligned = is_misaligned(i_pc);

  // Next-state, holding-register updates and the combinational request / PC-enable strobes.
  always_comb begin
    w_state_nxt     = r_state;
    w_drop_nxt      = r_drop;
    w_instr_nxt     = r_instr;
    w_instr_pc_nxt  = r_instr_pc;
    w_fetch_err_nxt = r_fetch_err;
    w_pc_en         = 1'b0;
    w_req           = 1'b0;

    unique case (r_state)
      ST_IDLE: begin
        if (i_flush) begin
          w_pc_en = 1'b1;
        end else begin
          w_state_nxt = ST_REQ;
        end
      end

      ST_REQ: begin
        if (i_flush) begin
          // Request suppressed so the redirected PC is fetched next cycle.
          w_pc_en = 1'b1;
        end else if (w_misaligned) begin
          // Fault is reported without touching memory.
          w_instr_pc_nxt  = i_pc;
          w_instr_nxt     = INSTR_FAULT_WORD;
          w_fetch_err_nxt = 1'b1;
          w_state_nxt     = ST_HOLD;
        end else begin
          w_req = 1'b1;
          if (bus.i_imem_gnt) begin
            w_instr_pc_nxt = i_pc;
            w_state_nxt    = ST_WAIT;
          end
        end
      end

      ST_WAIT: begin
        if (i_flush) begin
          w_pc_en = 1'b1;
          // A response landing in the flush cycle itself is the one being discarded,
          // so there is nothing left to drop afterwards.
          if (bus.i_imem_rvalid) begin
            w_drop_nxt  = 1'b0;
            w_state_nxt = ST_REQ;
          end else begin
            w_drop_nxt = 1'b1;
          end
        end else if (bus.i_imem_rvalid) begin
          if (r_drop) begin
            w_drop_nxt  = 1'b0;
            w_state_nxt = ST_REQ;
          end else begin
            w_instr_nxt     = bus.i_imem_rdata;
            w_fetch_err_nxt = bus.i_imem_err;
            w_state_nxt     = ST_HOLD;
          end
        end
      end

      ST_HOLD: begin
        if (i_flush || bus.i_instr_ready) begin
          w_pc_en     = 1'b1;
          w_state_nxt = ST_REQ;
        end
      end

      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  // State, drop flag and instruction holding registers.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_state     <= ST_IDLE;
      r_drop      <= 1'b0;
      r_instr     <= 32'h0;
      r_instr_pc  <= 32'h0;
      r_fetch_err <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_drop      <= w_drop_nxt;
      r_instr     <= w_instr_nxt;
      r_instr_pc  <= w_instr_pc_nxt;
      r_fetch_err <= w_fetch_err_nxt;
    end
  end

  // Strobes are gated by reset so nothing escapes while the state register is being cleared.
  assign o_pc_en           = w_pc_en & i_rst_n;
  assign bus.o_imem_req    = w_req & i_rst_n;
  assign bus.o_imem_addr   = bus.o_imem_req ? (i_pc & IMEM_ALIGN_MASK) : 32'h0;
  assign bus.o_instr_valid = (r_state == ST_HOLD);
  assign bus.o_instr       = r_instr;
  assign bus.o_instr_pc    = r_instr_pc;
  assign bus.o_fetch_err   = r_fetch_err;

endmodule

// File: doc/ifetch_ctrl.md
# ifetch_ctrl

Instruction-fetch controller between the PC generator, instruction memory and decode stage. It takes the current PC and issues a single-outstanding request to instruction memory. It holds the returned word for the core behind a valid/ready handshake and pulses `o_pc_en` to advance or redirect the PC generator. Because it is the only driver of the PC enable, it sets the fetch cadence of the multi-cycle core.

## Interface
Parameters: none (32-bit datapath fixed).

Ports:
- `i_clk` in 1: clock
- `i_rst_n` in 1: reset, synchronous, active-low
- `i_pc` in 32: current PC from the PC generator
- `o_pc_en` out 1: PC update enable; PC generator loads next PC on the same edge
- `o_imem_req` out 1: memory request
- `o_imem_addr` out 32: request address, word-aligned
- `i_imem_gnt` in 1: request accepted this cycle
- `i_imem_rvalid` in 1: response valid
- `i_imem_rdata` in 32: response data
- `i_imem_err` in 1: bus error, qualified by `i_imem_rvalid`
- `o_instr_valid` out 1: instruction available to decode
- `o_instr` out 32: instruction word
- `o_instr_pc` out 32: PC of `o_instr`
- `o_fetch_err` out 1: fetch fault tagged to the held instruction
- `i_instr_ready` in 1: decode accepts the instruction
- `i_flush` in 1: discard in-flight and held fetch; PC generator redirects with this cycle's `o_pc_en`

## Operation
- FSM states: IDLE, REQ, WAIT, HOLD.
- IDLE:
  - Entered on reset.
  - Goes to REQ unconditionally on the next cycle.
- REQ:
  - `o_imem_req`=1 and `o_imem_addr`={`i_pc`[31:2],2'b00}.
  - On `i_imem_gnt`, latch `i_pc` into the instruction-PC register and go to WAIT.
  - Misaligned `i_pc` (`i_pc`[1:0]≠0): no request is issued. Latch `i_pc` and go to HOLD with `o_fetch_err`=1 and `o_instr`=0.
- WAIT:
  - On `i_imem_rvalid`, register `i_imem_rdata` into `o_instr` and `i_imem_err` into `o_fetch_err`, then go to HOLD.
  - If the drop flag is set, discard the response, clear the flag and go to REQ.
- HOLD:
  - `o_instr_valid`=1.
  - On `i_instr_ready`, assert `o_pc_en` combinationally and go to REQ.
- `i_flush` has priority over everything and produces exactly one `o_pc_en` pulse. Per state:
  - IDLE: stay IDLE.
  - REQ: `o_imem_req` is forced to 0 and the state stays REQ.
  - WAIT: set the drop flag and stay in WAIT.
  - HOLD: drop the instruction (a same-cycle `i_instr_ready` is ignored) and go to REQ.
- Only one request is outstanding at a time. `i_imem_rvalid` is ignored in IDLE, REQ and HOLD.
- `o_pc_en` is never asserted outside a handshake or flush cycle, so the PC is stable throughout REQ and WAIT.

## Timing
- Reset values: state IDLE, drop flag 0.
  - All outputs are 0: `o_pc_en`, `o_imem_req`, `o_imem_addr`, `o_instr_valid`, `o_instr`, `o_instr_pc`, `o_fetch_err`.
- After `i_rst_n` rises: IDLE for 1 cycle, then REQ.
- Response timing:
  - `i_imem_rvalid` is legal no earlier than the cycle after the grant.
  - `o_instr_valid` rises the cycle after `i_imem_rvalid`.
- Zero-wait memory (grant in REQ, rvalid in the next cycle, ready in HOLD) gives 3 cycles per instruction: REQ→WAIT→HOLD→REQ.
- The REQ cycle after a handshake presents the updated PC.
- `o_instr`, `o_instr_pc` and `o_fetch_err` are stable while `o_instr_valid`=1.
- Reset mid-operation returns to IDLE within one edge. A stale `i_imem_rvalid` arriving afterwards is ignored.

## Structure
- `ifetch_pkg`:
  - State enum `ifetch_state_e`.
  - `IMEM_ALIGN_MASK` = 32'hFFFF_FFFC.
  - `INSTR_FAULT_WORD` = 32'h0.
- Single module, no sub-module: the FSM plus the data/PC/err holding registers and the drop flag.

## Test plan
- Reset held 3 cycles with `i_pc`=0, zero-wait memory returning 32'h0000_0013, ready tied 1:
  - All outputs are 0 during reset.
  - Request at `o_imem_addr`=0 two cycles after release.
  - `o_instr_valid` with `o_instr_pc`=0 and `o_pc_en` pulse; next request at 4.
- Grant delayed 3 cycles and rvalid delayed 2 cycles:
  - `o_imem_req` held with constant `o_imem_addr`.
  - No `o_pc_en`.
  - Instruction presented exactly once.
- `i_instr_ready`=0 for 5 cycles in HOLD:
  - `o_instr`, `o_instr_pc` and `o_instr_valid` stable.
  - `o_pc_en` pulses only on the cycle ready=1.
- `i_flush` in WAIT, then a response of 32'hDEAD_BEEF:
  - Single `o_pc_en` in the flush cycle.
  - Response discarded, `o_instr_valid` stays 0.
  - New request at the redirected PC.
- `i_pc`=32'h0000_0102 in REQ:
  - No `o_imem_req`.
  - HOLD with `o_fetch_err`=1, `o_instr`=0, `o_instr_pc`=32'h102.
- `i_imem_err`=1 with rvalid, and separately flush with ready in the same HOLD cycle:
  - Error case: `o_fetch_err`=1.
  - Flush+ready case: one `o_pc_en` pulse, FSM to REQ.
